// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared definitions for the data-memory responder: access-size encodings,
//   the responder FSM state type and the lane extract / merge helpers used to
//   implement byte and halfword accesses on a word-organised store.
//   Lanes are little-endian: byte k lives in bits [8k+7:8k].
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 is also handled as a word

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Select the addressed lane of a storage word and zero/sign-extend it.
  // Halfwords only look at lane[1] and words ignore the lane entirely, which is
  // what force-aligns misaligned accesses when trapping is disabled.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = {{24{sext & b[7]}}, b};
      SIZE_HALF: r = {{16{sext & h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Merge right-aligned store data into the lanes of the old storage word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] r;
    r = old_word;
    case (size)
      SIZE_BYTE: r[{lane, 3'b000} +: 8] = wdata[7:0];
      SIZE_HALF: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      default:   r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      default:   return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// dmem_word_ram
//   DEPTH_WORDS x 32 storage with one synchronous read port and one
//   synchronous write port. Contents are never reset.
//   Ports:
//     clk      rising-edge clock
//     rd_en    capture mem[rd_addr] into rd_data at the next edge
//     rd_addr  read word index
//     rd_data  registered read data
//     wr_en    write wr_data into mem[wr_addr] at the next edge
//     wr_addr  write word index
//     wr_data  write data
module dmem_word_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem [0:DEPTH_WORDS-1];

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the core's load/store port. A request accepted
//   in IDLE reads its storage word, ACCESS either extracts/extends the load
//   lane or merges and writes back the store lanes, and RESP pulses
//   resp_valid. Fixed latency: accept at edge T, resp_valid during cycle T+2.
//   Optional feature macro: DMEM_MISALIGN_TRAP_EN
//     defined   - misaligned half/word accesses are rejected (resp_err=1,
//                 resp_rdata=0, no write)
//     undefined - misaligned accesses are force-aligned, resp_err is 0
//   Ports:
//     clk, rst                   clock, asynchronous active-high reset
//     req_valid / req_ready      request handshake
//     req_write, req_size,
//     req_signed, req_addr,
//     req_wdata                  request fields (store data right-aligned)
//     resp_valid                 one-cycle completion pulse
//     resp_rdata                 extended load data (0 for stores/errors)
//     resp_err                   misaligned access rejected
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t        state_reg;
  logic          write_reg;
  logic [1:0]    size_reg;
  logic          signed_reg;
  logic [AW+1:0] addr_reg;     // only the bits inside the wrapped address space
  logic [31:0]   wdata_reg;
  logic          resp_valid_reg;
  logic [31:0]   rdata_reg;
  logic          err_reg;

  logic          accept;
  logic          trap;
  logic          ram_wr_en;
  logic [31:0]   ram_rd_data;
  logic [31:0]   merged_word;

  // Address bits above the word index are ignored so addresses wrap.
  logic          addr_hi_unused;
  assign addr_hi_unused = ^req_addr[31:AW+2];

  // Ready drops as soon as rst rises, not only at the next edge.
  assign req_ready = (state_reg == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = is_misaligned(size_reg, addr_reg[1:0]);
`else
  assign trap = 1'b0;
`endif

  // Write strobe is derived from the live state, so an asynchronous reset in
  // ACCESS moves the FSM to IDLE before the commit edge and suppresses it.
  assign ram_wr_en   = (state_reg == ST_ACCESS) && write_reg && !trap;
  assign merged_word = lane_merge(ram_rd_data, wdata_reg, size_reg, addr_reg[1:0]);

  dmem_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .rd_en   (accept),
    .rd_addr (req_addr[AW+1:2]),
    .rd_data (ram_rd_data),
    .wr_en   (ram_wr_en),
    .wr_addr (addr_reg[AW+1:2]),
    .wr_data (merged_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      write_reg      <= 1'b0;
      size_reg       <= SIZE_BYTE;
      signed_reg     <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      resp_valid_reg <= 1'b0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            write_reg  <= req_write;
            size_reg   <= req_size;
            signed_reg <= req_signed;
            addr_reg   <= req_addr[AW+1:0];
            wdata_reg  <= req_wdata;
            state_reg  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          resp_valid_reg <= 1'b1;
          err_reg        <= trap;
          if (write_reg || trap) rdata_reg <= '0;
          else rdata_reg <= lane_extract(ram_rd_data, size_reg, addr_reg[1:0], signed_reg);
          state_reg      <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid_reg <= 1'b0;
          state_reg      <= ST_IDLE;
        end
        default: begin
          resp_valid_reg <= 1'b0;
          state_reg      <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Self-checking bench for dmem_responder. A byte-addressed reference memory
//   predicts every response; directed cases also compare against literal
//   values. Honours DMEM_MISALIGN_TRAP_EN in the same way as the design.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int BYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_mem [0:BYTES-1];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit misaligned(input logic [31:0] addr, input logic [1:0] size);
    return (addr % nbytes(size)) != 0;
  endfunction

  // Reference behaviour: byte-addressed memory of 4*DEPTH bytes.
  task automatic model_xact(input logic write, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] exp_rdata, output logic exp_err);
    int unsigned a;
    int n;
    logic [31:0] v;
    exp_rdata = 32'd0;
    exp_err   = 1'b0;
    n = nbytes(size);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (misaligned(addr, size)) begin
      exp_err = 1'b1;
      return;
    end
`endif
    a = addr % BYTES;
    a = a - (a % n);
    if (write) begin
      for (int i = 0; i < n; i++) model_mem[a + i] = 8'(wdata >> (8 * i));
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v + (32'(model_mem[a + i]) << (8 * i));
      if (sgn && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      exp_rdata = v;
    end
  endtask

  // Issue one request from a negedge; returns at the negedge after the
  // response, with the design back in IDLE.
  task automatic do_xact(input string tag, input logic write, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit keep_valid, output logic [31:0] got_rdata);
    logic [31:0] er;
    logic        ee;
    int          waited;
    req_valid  = 1'b1;
    req_write  = write;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    got_rdata  = 32'd0;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    model_xact(write, size, sgn, addr, wdata, er, ee);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) req_valid = 1'b0;
    check({tag, "_access_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_access_ready"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    got_rdata = resp_rdata;
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_resp_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rdata"}, resp_rdata, er);
    check({tag, "_err"}, 32'(resp_err), 32'(ee));
    $display("xact %s: %s size=%0d sgn=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
             tag, write ? "ST" : "LD", size, sgn, addr, wdata, resp_rdata, resp_err);
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
  endtask

  logic [31:0] got;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", 32'(req_ready), 32'd1);

    // Give every storage word a known value.
    for (int w = 0; w < DEPTH; w++)
      do_xact("preload", 1'b1, 2'd2, 1'b0, 32'(4 * w), 32'd0, 1'b0, got);

    // Word store/load and sub-word access.
    do_xact("st_w10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, got);
    check("st_w10_zero", got, 32'd0);
    do_xact("ld_w10", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, got);
    check("ld_w10_lit", got, 32'hDEADBEEF);
    do_xact("st_b12", 1'b1, 2'd0, 1'b0, 32'h12, 32'h55, 1'b0, got);
    do_xact("ld_sb13", 1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 1'b0, got);
    check("ld_sb13_lit", got, 32'hFFFFFFDE);
    do_xact("ld_uh12", 1'b0, 2'd1, 1'b0, 32'h12, 32'd0, 1'b0, got);
    check("ld_uh12_lit", got, 32'h0000DE55);
    do_xact("ld_w10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, got);
    check("ld_w10b_lit", got, 32'hDE55BEEF);

    // Halfword sign extension.
    do_xact("st_8001", 1'b1, 2'd2, 1'b0, 32'h10, 32'h00008001, 1'b0, got);
    do_xact("ld_sh10", 1'b0, 2'd1, 1'b1, 32'h10, 32'd0, 1'b0, got);
    check("ld_sh10_lit", got, 32'hFFFF8001);
    do_xact("ld_uh10", 1'b0, 2'd1, 1'b0, 32'h10, 32'd0, 1'b0, got);
    check("ld_uh10_lit", got, 32'h00008001);

    // Address wrap; store with valid held through ACCESS/RESP, then the load
    // only gets accepted once the design is back in IDLE.
    do_xact("st_w0", 1'b1, 2'd2, 1'b0, 32'h0, 32'h11223344, 1'b1, got);
    do_xact("ld_wrap", 1'b0, 2'd2, 1'b0, 32'(BYTES), 32'd0, 1'b0, got);
    check("ld_wrap_lit", got, 32'h11223344);

    // Misaligned halfword store.
    do_xact("st_w20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h01020304, 1'b0, got);
    do_xact("st_h21", 1'b1, 2'd1, 1'b0, 32'h21, 32'h0000ABCD, 1'b0, got);
    do_xact("ld_w20", 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b0, got);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("ld_w20_lit", got, 32'h01020304);
`else
    check("ld_w20_lit", got, 32'h0102ABCD);
`endif

    // Reset during ACCESS of a store: no write, no response.
    do_xact("st_w30", 1'b1, 2'd2, 1'b0, 32'h30, 32'h0BADF00D, 1'b0, got);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("midrst_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rel_ready", 32'(req_ready), 32'd1);
    check("midrst_novalid", 32'(resp_valid), 32'd0);
    $display("xact midrst: ST aborted addr=00000030 wdata=cafef00d");
    do_xact("ld_w30", 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 1'b0, got);
    check("ld_w30_lit", got, 32'h0BADF00D);

    // Randomized traffic across twice the address space (exercises wrap).
    for (int i = 0; i < 200; i++) begin
      logic        w;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] ad;
      logic [31:0] wd;
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      ad = 32'($urandom_range(0, 2 * BYTES - 1));
      wd = $urandom;
      do_xact($sformatf("rnd%0d", i), w, sz, sg, ad, wd, bit'($urandom_range(0, 1)), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
